// File: rtl/register_bank.sv
// Parametrised general-purpose register bank: one write, one in-place +/-1 step
// and a global synchronous clear per cycle, with two combinational read ports.
module register_bank #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_REGS    = 8,
  parameter int               ADDR_W      = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              step_en,
  input  logic [ADDR_W-1:0] step_addr,
  input  logic              step_dn,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              zero_a,
  output logic              wrap,
  output logic              err
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] step_hit;
  logic [WIDTH-1:0]    step_cur;
  logic [WIDTH-1:0]    step_nxt;
  logic                wr_in_range;
  logic                step_in_range;
  logic                step_take;
  logic                wrap_p0;
  logic                err_p0;

  // Modulo-2^WIDTH increment/decrement; wrap-around is intentional.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                  input logic             dn);
    return dn ? (cur - WIDTH'(1)) : (cur + WIDTH'(1));
  endfunction

  function automatic logic step_wraps(input logic [WIDTH-1:0] cur,
                                      input logic             dn);
    return dn ? (cur == '0) : (cur == '1);
  endfunction

  // Address decode; an address matching no register is out of range.
  always_comb begin
    wr_hit   = '0;
    step_hit = '0;
    step_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (waddr == ADDR_W'(i)) wr_hit[i] = we;
      if (step_addr == ADDR_W'(i)) begin
        step_hit[i] = step_en;
        step_cur    = regs[i];
      end
    end
    wr_in_range   = |wr_hit;
    step_in_range = |step_hit;
    // A write to the same register drops the step, including its wrap pulse.
    step_take     = step_in_range && !(|(wr_hit & step_hit));
    step_nxt      = step_value(step_cur, step_dn);
    wrap_p0       = step_take && step_wraps(step_cur, step_dn);
    err_p0        = (we && !wr_in_range) || (step_en && !step_in_range);
  end

  // ---- stage p0 -> register storage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr)              regs[i] <= RESET_VALUE;
        else if (wr_hit[i])   regs[i] <= wdata;
        else if (step_hit[i]) regs[i] <= step_nxt;
      end
    end
  end

  // ---- stage p0 -> status pulses ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (clr) begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= wrap_p0;
      err  <= err_p0;
    end
  end

  // Read ports see stored contents only; out-of-range addresses read as zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_a == ADDR_W'(i)) rdata_a = regs[i];
      if (raddr_b == ADDR_W'(i)) rdata_b = regs[i];
    end
    zero_a = (rdata_a == '0);
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: an 8-register bank and a 6-register bank (with a
// nonzero reset value) share stimulus and are checked against a behavioural model.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset, clr, we, step_en, step_dn;
  logic [2:0]  waddr, step_addr, raddr_a, raddr_b;
  logic [31:0] wdata;

  logic [31:0] ra8, rb8, ra6, rb6;
  logic        z8, z6, wrap8, wrap6, err8, err6;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m [2][8];
  int          nr [2] = '{8, 6};
  logic [31:0] rv [2] = '{32'h0, 32'hA5};
  logic        ew [2];
  logic        ee [2];

  always #5 clk = ~clk;

  register_bank #(.WIDTH(32), .NUM_REGS(8), .RESET_VALUE(32'h0)) dut8 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .step_en(step_en), .step_addr(step_addr), .step_dn(step_dn),
    .raddr_a(raddr_a), .rdata_a(ra8), .raddr_b(raddr_b), .rdata_b(rb8),
    .zero_a(z8), .wrap(wrap8), .err(err8));

  register_bank #(.WIDTH(32), .NUM_REGS(6), .RESET_VALUE(32'hA5)) dut6 (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .step_en(step_en), .step_addr(step_addr), .step_dn(step_dn),
    .raddr_a(raddr_a), .rdata_a(ra6), .raddr_b(raddr_b), .rdata_b(rb6),
    .zero_a(z6), .wrap(wrap6), .err(err6));

  function automatic logic [31:0] exp_rd(int k, logic [2:0] a);
    return (int'(a) < nr[k]) ? m[k][a] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m[k][i] = rv[k];
      ew[k] = 1'b0;
      ee[k] = 1'b0;
    end
  endtask

  // Next state of each bank from the rules: clear beats write beats step.
  task automatic model_edge();
    logic [31:0] old;
    for (int k = 0; k < 2; k++) begin
      ew[k] = 1'b0;
      ee[k] = 1'b0;
      if (clr) begin
        for (int i = 0; i < 8; i++) m[k][i] = rv[k];
      end else begin
        ee[k] = (we && int'(waddr) >= nr[k]) || (step_en && int'(step_addr) >= nr[k]);
        if (step_en && int'(step_addr) < nr[k] && !(we && waddr == step_addr)) begin
          old = m[k][step_addr];
          ew[k] = step_dn ? (old == 32'h0) : (old == 32'hFFFF_FFFF);
          m[k][step_addr] = step_dn ? old - 32'd1 : old + 32'd1;
        end
        if (we && int'(waddr) < nr[k]) m[k][waddr] = wdata;
      end
    end
  endtask

  task automatic idle();
    clr = 0; we = 0; step_en = 0; step_dn = 0;
    waddr = 0; step_addr = 0; wdata = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; idle(); raddr_a = 3; raddr_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ra8 !== 32'h0) $display("FAIL reset_rdata8 got %h want %h", ra8, 32'h0); else n_pass++;
    n_total++; if (ra6 !== 32'hA5) $display("FAIL reset_rdata6 got %h want %h", ra6, 32'hA5); else n_pass++;
    n_total++; if ({wrap8, err8, wrap6, err6} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {wrap8, err8, wrap6, err6}); else n_pass++;
    @(negedge clk); reset = 1;
    we = 1; waddr = 3; wdata = 32'h1234_5678;
    tick();
    idle();
    n_total++; if (ra8 !== 32'h1234_5678) $display("FAIL load_r3 got %h want %h", ra8, 32'h1234_5678); else n_pass++;
    #3 reset = 0;
    #1;
    model_reset();
    n_total++; if (ra8 !== 32'h0) $display("FAIL async_reset8 got %h want %h", ra8, 32'h0); else n_pass++;
    n_total++; if (ra6 !== 32'hA5) $display("FAIL async_reset6 got %h want %h", ra6, 32'hA5); else n_pass++;
    n_total++; if ({wrap8, err8} !== 2'b0) $display("FAIL async_reset_flags got %b want 00", {wrap8, err8}); else n_pass++;
    @(negedge clk); reset = 1;
  endtask

  task automatic test_write_read();
    we = 1; waddr = 5; wdata = 32'hDEAD_BEEF; raddr_a = 5; raddr_b = 5;
    tick();
    idle();
    n_total++; if (ra8 !== 32'hDEAD_BEEF) $display("FAIL wr_rdata_a got %h want %h", ra8, 32'hDEAD_BEEF); else n_pass++;
    n_total++; if (rb8 !== 32'hDEAD_BEEF) $display("FAIL wr_rdata_b got %h want %h", rb8, 32'hDEAD_BEEF); else n_pass++;
    n_total++; if (z8 !== 1'b0) $display("FAIL wr_zero_a got %b want 0", z8); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      n_total++; if (ra8 !== exp_rd(0, raddr_a)) $display("FAIL wr_sweep8[%0d] got %h want %h", i, ra8, exp_rd(0, raddr_a)); else n_pass++;
      n_total++; if (ra6 !== exp_rd(1, raddr_a)) $display("FAIL wr_sweep6[%0d] got %h want %h", i, ra6, exp_rd(1, raddr_a)); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    we = 1; waddr = 2; wdata = 32'hFFFF_FFFF;
    tick();
    idle(); step_en = 1; step_addr = 2; step_dn = 0; raddr_a = 2;
    tick();
    idle();
    n_total++; if (ra8 !== 32'h0) $display("FAIL inc_wrap_val got %h want %h", ra8, 32'h0); else n_pass++;
    n_total++; if (z8 !== 1'b1) $display("FAIL inc_wrap_zero got %b want 1", z8); else n_pass++;
    n_total++; if (wrap8 !== 1'b1) $display("FAIL inc_wrap_pulse got %b want 1", wrap8); else n_pass++;
    n_total++; if (wrap6 !== ew[1]) $display("FAIL inc_wrap_pulse6 got %b want %b", wrap6, ew[1]); else n_pass++;
    tick();
    n_total++; if (wrap8 !== 1'b0) $display("FAIL inc_wrap_end got %b want 0", wrap8); else n_pass++;
    step_en = 1; step_addr = 2; step_dn = 1;
    tick();
    idle();
    n_total++; if (ra8 !== 32'hFFFF_FFFF) $display("FAIL dec_wrap_val got %h want %h", ra8, 32'hFFFF_FFFF); else n_pass++;
    n_total++; if (wrap8 !== 1'b1) $display("FAIL dec_wrap_pulse got %b want 1", wrap8); else n_pass++;
    tick();
    n_total++; if (wrap8 !== 1'b0) $display("FAIL dec_wrap_end got %b want 0", wrap8); else n_pass++;
  endtask

  task automatic test_collision();
    we = 1; waddr = 6; wdata = 32'd7;
    tick();
    we = 1; waddr = 4; wdata = 32'hFFFF_FFFF;
    tick();
    we = 1; waddr = 4; wdata = 32'h10; step_en = 1; step_addr = 4; step_dn = 0; raddr_a = 4;
    tick();
    idle();
    n_total++; if (ra8 !== 32'h10) $display("FAIL coll_same_val got %h want %h", ra8, 32'h10); else n_pass++;
    n_total++; if (wrap8 !== 1'b0) $display("FAIL coll_same_wrap got %b want 0", wrap8); else n_pass++;
    we = 1; waddr = 4; wdata = 32'h10; step_en = 1; step_addr = 6; raddr_b = 6;
    tick();
    idle();
    n_total++; if (ra8 !== 32'h10) $display("FAIL coll_diff_w got %h want %h", ra8, 32'h10); else n_pass++;
    n_total++; if (rb8 !== 32'd8) $display("FAIL coll_diff_step got %h want %h", rb8, 32'd8); else n_pass++;
  endtask

  task automatic test_clear();
    we = 1; waddr = 1; wdata = 32'h55;
    tick();
    clr = 1; we = 1; waddr = 1; wdata = 32'hAA; step_en = 1; step_addr = 7; raddr_b = 1;
    tick();
    idle();
    n_total++; if (rb8 !== 32'h0) $display("FAIL clr_r1 got %h want %h", rb8, 32'h0); else n_pass++;
    n_total++; if (err6 !== 1'b0) $display("FAIL clr_err6 got %b want 0", err6); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      n_total++; if (ra8 !== 32'h0) $display("FAIL clr_sweep8[%0d] got %h want %h", i, ra8, 32'h0); else n_pass++;
      n_total++; if (ra6 !== exp_rd(1, raddr_a)) $display("FAIL clr_sweep6[%0d] got %h want %h", i, ra6, exp_rd(1, raddr_a)); else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    we = 1; waddr = 7; wdata = 32'h123; raddr_b = 7;
    tick();
    idle();
    n_total++; if (err6 !== 1'b1) $display("FAIL oor_wr_err6 got %b want 1", err6); else n_pass++;
    n_total++; if (err8 !== 1'b0) $display("FAIL oor_wr_err8 got %b want 0", err8); else n_pass++;
    n_total++; if (rb6 !== 32'h0) $display("FAIL oor_read6 got %h want %h", rb6, 32'h0); else n_pass++;
    n_total++; if (rb8 !== 32'h123) $display("FAIL inrange_read8 got %h want %h", rb8, 32'h123); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      raddr_a = 3'(i);
      #1;
      n_total++; if (ra6 !== exp_rd(1, raddr_a)) $display("FAIL oor_sweep6[%0d] got %h want %h", i, ra6, exp_rd(1, raddr_a)); else n_pass++;
    end
    tick();
    n_total++; if (err6 !== 1'b0) $display("FAIL oor_err_end got %b want 0", err6); else n_pass++;
    step_en = 1; step_addr = 6;
    tick();
    idle();
    n_total++; if (err6 !== 1'b1) $display("FAIL oor_step_err6 got %b want 1", err6); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr       = ($urandom_range(0, 24) == 0);
      we        = $urandom_range(0, 1) == 1;
      waddr     = 3'($urandom_range(0, 7));
      step_en   = $urandom_range(0, 2) != 0;
      step_addr = 3'($urandom_range(0, 7));
      step_dn   = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       wdata = 32'h0;
        1:       wdata = 32'hFFFF_FFFF;
        2:       wdata = 32'h1;
        default: wdata = $urandom;
      endcase
      raddr_a   = 3'($urandom_range(0, 7));
      raddr_b   = 3'($urandom_range(0, 7));
      tick();
      n_total++; if (ra8 !== exp_rd(0, raddr_a)) $display("FAIL rnd_ra8 c%0d got %h want %h", c, ra8, exp_rd(0, raddr_a)); else n_pass++;
      n_total++; if (rb8 !== exp_rd(0, raddr_b)) $display("FAIL rnd_rb8 c%0d got %h want %h", c, rb8, exp_rd(0, raddr_b)); else n_pass++;
      n_total++; if (ra6 !== exp_rd(1, raddr_a)) $display("FAIL rnd_ra6 c%0d got %h want %h", c, ra6, exp_rd(1, raddr_a)); else n_pass++;
      n_total++; if (rb6 !== exp_rd(1, raddr_b)) $display("FAIL rnd_rb6 c%0d got %h want %h", c, rb6, exp_rd(1, raddr_b)); else n_pass++;
      n_total++; if (z8 !== (exp_rd(0, raddr_a) == 32'h0)) $display("FAIL rnd_z8 c%0d got %b", c, z8); else n_pass++;
      n_total++; if (z6 !== (exp_rd(1, raddr_a) == 32'h0)) $display("FAIL rnd_z6 c%0d got %b", c, z6); else n_pass++;
      n_total++; if (wrap8 !== ew[0]) $display("FAIL rnd_wrap8 c%0d got %b want %b", c, wrap8, ew[0]); else n_pass++;
      n_total++; if (wrap6 !== ew[1]) $display("FAIL rnd_wrap6 c%0d got %b want %b", c, wrap6, ew[1]); else n_pass++;
      n_total++; if (err8 !== ee[0]) $display("FAIL rnd_err8 c%0d got %b want %b", c, err8, ee[0]); else n_pass++;
      n_total++; if (err6 !== ee[1]) $display("FAIL rnd_err6 c%0d got %b want %b", c, err6, ee[1]); else n_pass++;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_collision();
    test_clear();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
